// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: PC register, combinational ROM address and IF/ID register.
// Optional FETCH_MISALIGN_EN traps misaligned redirects to TRAP_VECTOR and flags o_Misalign.
module fetch_stage #(
  parameter int unsigned                  ADDR_WIDTH   = 32,
  parameter int unsigned                  INST_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_VECTOR = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0]        NOP_INST     = 32'h0000_0013
`ifdef FETCH_MISALIGN_EN
  ,
  parameter logic [ADDR_WIDTH-1:0]        TRAP_VECTOR  = 32'h0000_0010
`endif
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  output logic [ADDR_WIDTH-1:0] o_PgmAddr,
  input  logic [INST_WIDTH-1:0] i_PgmInst,
  input  logic                  i_Stall,
  input  logic                  i_Redirect,
  input  logic [ADDR_WIDTH-1:0] i_RedirectAddr,
  output logic [INST_WIDTH-1:0] o_Inst,
  output logic [ADDR_WIDTH-1:0] o_PC,
  output logic                  o_Valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                  o_Misalign
`endif
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] opc_q, opc_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  misalign;

`ifdef FETCH_MISALIGN_EN
  logic mis_q, mis_d;

  assign misalign    = |i_RedirectAddr[1:0];
  assign redirect_pc = misalign ? TRAP_VECTOR : i_RedirectAddr;
`else
  // Targets are word-aligned by clearing the low two bits.
  assign misalign    = 1'b0;
  assign redirect_pc = i_RedirectAddr & ~ADDR_WIDTH'(3);
`endif

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    valid_d = valid_q;
`ifdef FETCH_MISALIGN_EN
    mis_d   = 1'b0;
`endif
    if (i_Redirect) begin
      // Drop the word currently at the ROM output and insert a bubble.
      pc_d    = redirect_pc;
      inst_d  = NOP_INST;
      opc_d   = pc_q;
      valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
      mis_d   = misalign;
`endif
    end else if (!i_Stall) begin
      inst_d  = i_PgmInst;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pc_q    <= RESET_VECTOR;
      inst_q  <= NOP_INST;
      opc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign o_Misalign = mis_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif

  assign o_PgmAddr = pc_q;
  assign o_Inst    = inst_q;
  assign o_PC      = opc_q;
  assign o_Valid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a combinational ROM model.
// Misalign expectations are selected by FETCH_MISALIGN_EN.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pgm_addr;
  logic [31:0] pgm_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] inst;
  logic [31:0] opc;
  logic        valid;
`ifdef FETCH_MISALIGN_EN
  logic        misalign;
  localparam logic [31:0] MisPc = 32'h0000_0010;
  localparam logic [31:0] MisInst = 32'h5A5A_0010;
`else
  localparam logic [31:0] MisPc = 32'h0000_0100;
  localparam logic [31:0] MisInst = 32'h5A5A_0100;
`endif

  int n_applied = 0;
  int n_miss = 0;

  fetch_stage dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .o_PgmAddr      (pgm_addr),
    .i_PgmInst      (pgm_inst),
    .i_Stall        (stall),
    .i_Redirect     (redirect),
    .i_RedirectAddr (redirect_addr),
    .o_Inst         (inst),
    .o_PC           (opc),
    .o_Valid        (valid)
`ifdef FETCH_MISALIGN_EN
    ,
    .o_Misalign     (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: three fixed words at 0/4/8, elsewhere the address xor a marker.
  always_comb begin
    case (pgm_addr)
      32'h0:   pgm_inst = 32'h1111_1111;
      32'h4:   pgm_inst = 32'h2222_2222;
      32'h8:   pgm_inst = 32'h3333_3333;
      default: pgm_inst = pgm_addr ^ 32'h5A5A_0000;
    endcase
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] raddr;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        chk_pc;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " addr"}, pgm_addr, 32'h0);
    chk({tag, " inst"}, inst, 32'h13);
    chk({tag, " pc"}, opc, 32'h0);
    chk({tag, " valid"}, {31'b0, valid}, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk({tag, " mis"}, {31'b0, misalign}, 32'h0);
`endif
  endtask

  initial begin
    //             stall redir raddr          addr           inst           pc            chk  v  mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h1111_1111, 32'h0,         1, 1, 0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'h2222_2222, 32'h4,         1, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h2222_2222, 32'h4,         1, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h2222_2222, 32'h4,         1, 1, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h2222_2222, 32'h4,         1, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'h3333_3333, 32'h8,         1, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,        32'h40,        32'h13,        32'h0,         0, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h44,        32'h5A5A_0040, 32'h40,        1, 1, 0};
    vecs[8]  = '{1'b1, 1'b1, 32'h80,        32'h80,        32'h13,        32'h0,         0, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         32'h80,        32'h13,        32'h0,         0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h84,        32'h5A5A_0080, 32'h80,        1, 1, 0};
    vecs[11] = '{1'b0, 1'b1, 32'h103,       MisPc,         32'h13,        32'h0,         0, 0, 1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         MisPc + 32'h4, MisInst,       MisPc,         1, 1, 0};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h13,        32'h0,         0, 0, 0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'hA5A5_FFFC, 32'hFFFF_FFFC, 1, 1, 0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h1111_1111, 32'h0,         1, 1, 0};

    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redirect;
      redirect_addr = vecs[i].raddr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr", i), pgm_addr, vecs[i].e_addr);
      chk($sformatf("v%0d inst", i), inst, vecs[i].e_inst);
      if (vecs[i].chk_pc) chk($sformatf("v%0d pc", i), opc, vecs[i].e_pc);
      chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
`ifdef FETCH_MISALIGN_EN
      chk($sformatf("v%0d mis", i), {31'b0, misalign}, {31'b0, vecs[i].e_mis});
`endif
    end
    stall = 1'b0;
    redirect = 1'b0;

    // Async reset between edges: state must clear with no clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async reset");
    @(posedge clk);
    #1;
    chk_reset("reset held");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release addr", pgm_addr, 32'h4);
    chk("release inst", inst, 32'h1111_1111);
    chk("release pc", opc, 32'h0);
    chk("release valid", {31'b0, valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
